// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch sequencer and its instruction queue.
//   - ADDR_W / WORD_W / ENTRY_W : address, instruction word and queue entry widths
//   - fetch_state_e             : fetch FSM state encoding
//   - fetch_entry_t             : queue entry layout {word, pc, fault}, 97 bits
//   - word_align()              : clears the byte-offset bits of an address
package fetch_pkg;

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned ENTRY_W = WORD_W + ADDR_W + 1;

   typedef enum logic [1:0] {
      F_IDLE  = 2'd0,
      F_WAIT  = 2'd1,
      F_FLUSH = 2'd2,
      F_HALT  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [ADDR_W-1:0] pc;
      logic              fault;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between the fetch FSM and the decoder.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : empties the queue; overrides push and pop in the same cycle
//   push, push_entry  : write one entry at the tail (ignored when full)
//   pop               : remove the head entry (ignored when empty)
//   count             : number of valid entries
//   head_valid        : queue non-empty
//   head_entry        : head entry, all zeros while the queue is empty
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output fetch_entry_t             head_entry
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   fetch_entry_t     mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_CNT) && !flush;
      do_pop   = pop && (count_q != '0) && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing reads it while count_q is zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry;
   end

   always_comb begin
      count      = count_q;
      head_valid = (count_q != '0);
      head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM, fetch PC and instruction queue.
//   clk, rst                        : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc     : flush the queue and restart fetch at redirect_pc
//   mem_req, mem_addr               : single-outstanding fetch request, word aligned
//   mem_ack, mem_rdata, mem_err     : request completion, data and bus fault
//   inst_valid, inst_ready          : decoder handshake for the queue head
//   inst_word, inst_pc, inst_fault  : queue head contents, zero when inst_valid is low
// Configuration: define FETCH_PREFETCH_EN to let fetch run ahead until the queue is
// full; otherwise a new request is issued only when the queue is empty.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_word,
   output logic [63:0] inst_pc,
   output logic        inst_fault
);

   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              q_push;
   fetch_entry_t      q_entry;
   logic [CNT_W-1:0]  q_count;
   logic              q_head_valid;
   fetch_entry_t      q_head;
   logic              credit;

   // Credit is only evaluated in F_IDLE, where nothing is outstanding, so the
   // queue count alone decides whether another entry can be accepted.
   always_comb begin
`ifdef FETCH_PREFETCH_EN
      credit = (q_count < DEPTH_CNT);
`else
      credit = (q_count == '0);
`endif
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      q_push     = 1'b0;
      q_entry    = '0;
      unique case (state_q)
         F_IDLE: begin
            if (redirect_valid) begin
               fetch_pc_d = word_align(redirect_pc);
            end else if (credit) begin
               addr_d  = fetch_pc_q;
               state_d = F_WAIT;
            end
         end
         F_WAIT: begin
            if (redirect_valid) begin
               fetch_pc_d = word_align(redirect_pc);
               // Same-cycle ack completes the request; otherwise drain it first.
               state_d    = mem_ack ? F_IDLE : F_FLUSH;
            end else if (mem_ack) begin
               q_push = 1'b1;
               if (mem_err) begin
                  q_entry = '{word: '0, pc: addr_q, fault: 1'b1};
                  state_d = F_HALT;
               end else begin
                  q_entry    = '{word: mem_rdata, pc: addr_q, fault: 1'b0};
                  fetch_pc_d = fetch_pc_q + 64'd4;
                  state_d    = F_IDLE;
               end
            end
         end
         F_FLUSH: begin
            if (redirect_valid) fetch_pc_d = word_align(redirect_pc);
            if (mem_ack)        state_d    = F_IDLE;
         end
         F_HALT: begin
            if (redirect_valid) begin
               fetch_pc_d = word_align(redirect_pc);
               state_d    = F_IDLE;
            end
         end
         default: state_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= F_IDLE;
         fetch_pc_q <= word_align(RESET_PC);
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   always_comb begin
      mem_req    = (state_q == F_WAIT) || (state_q == F_FLUSH);
      mem_addr   = addr_q;
      inst_valid = q_head_valid;
      inst_word  = q_head.word;
      inst_pc    = q_head.pc;
      inst_fault = q_head.fault;
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (q_push),
      .push_entry (q_entry),
      .pop        (inst_ready),
      .count      (q_count),
      .head_valid (q_head_valid),
      .head_entry (q_head)
   );

endmodule
